// File: rtl/writeback_merge.sv
// Writeback merge: ALU results take priority over load returns. Load returns that
// cannot be written at once wait in an in-order queue. Stale queued loads are squashed.
module writeback_merge #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int LQ_DEPTH = 4
) (
    input  logic                        elk,
    input  logic                        nrst,
    input  logic                        alu_valid,
    input  logic [ADDR_W-1:0]           alu_addr,
    input  logic [DATA_W-1:0]           alu_data,
    input  logic                        ld_valid,
    output logic                        ld_ready,
    input  logic [ADDR_W-1:0]           ld_addr,
    input  logic [DATA_W-1:0]           ld_data,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    output logic [$clog2(LQ_DEPTH):0]   lq_count,
    output logic                        squash_pulse
);
    localparam int PTR_W = $clog2(LQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [LQ_DEPTH-1:0]             q_valid;
    logic [LQ_DEPTH-1:0][ADDR_W-1:0] q_addr;
    logic [LQ_DEPTH-1:0][DATA_W-1:0] q_data;
    logic [PTR_W-1:0]                head, tail;

    logic                accept, empty, enq, deq, squash, ld_kill, any_kill;
    logic [LQ_DEPTH-1:0] kill_vec;
    logic                sel_valid;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;

    // Registered count only, so ready never depends on a same-cycle dequeue.
    assign ld_ready = (lq_count < CNT_W'(LQ_DEPTH));

    always_comb begin
        accept   = ld_valid && ld_ready;
        empty    = (lq_count == '0);
        deq      = !alu_valid && !empty;
        enq      = accept && (alu_valid || !empty);
        squash   = alu_valid && (alu_addr != '0);
        ld_kill  = squash && (ld_addr == alu_addr);
        for (int i = 0; i < LQ_DEPTH; i++)
            kill_vec[i] = squash && q_valid[i] && (q_addr[i] == alu_addr);
        any_kill = (|kill_vec) || (enq && ld_kill);

        sel_valid = 1'b0;
        sel_addr  = alu_addr;
        sel_data  = alu_data;
        if (alu_valid) begin
            sel_valid = (alu_addr != '0);
        end else if (!empty) begin
            // A killed head still consumes its slot and writes nothing.
            sel_valid = q_valid[head] && (q_addr[head] != '0);
            sel_addr  = q_addr[head];
            sel_data  = q_data[head];
        end else if (accept) begin
            sel_valid = (ld_addr != '0);
            sel_addr  = ld_addr;
            sel_data  = ld_data;
        end
    end

    always_ff @(posedge elk or negedge nrst) begin
        if (!nrst) begin
            q_valid      <= '0;
            q_addr       <= '0;
            q_data       <= '0;
            head         <= '0;
            tail         <= '0;
            lq_count     <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            squash_pulse <= 1'b0;
        end else begin
            for (int i = 0; i < LQ_DEPTH; i++)
                if (kill_vec[i]) q_valid[i] <= 1'b0;
            if (deq) begin
                q_valid[head] <= 1'b0;
                head          <= head + PTR_W'(1);
            end
            // Tail is never live here: accept implies the queue is not full.
            if (enq) begin
                q_valid[tail] <= !ld_kill;
                q_addr[tail]  <= ld_addr;
                q_data[tail]  <= ld_data;
                tail          <= tail + PTR_W'(1);
            end
            lq_count     <= lq_count + CNT_W'(enq) - CNT_W'(deq);
            squash_pulse <= any_kill;
            wr_en        <= sel_valid;
            if (sel_valid) begin
                wr_addr <= sel_addr;
                wr_data <= sel_data;
            end
        end
    end
endmodule
